// File: rtl/ramb16_s9_ctrl.sv
// Single-port access controller for an X_RAMB16_S9 block RAM: request stream to
// registered RAM port, parity generate/check, 2-cycle read response, background fill.
module ramb16_s9_ctrl #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        CLK,
    input  logic        SSR,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [10:0] REQ_ADDR,
    input  logic [7:0]  REQ_DATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_PERR,
    output logic [15:0] PERR_CNT,
    input  logic        FILL_START,
    input  logic [7:0]  FILL_DATA,
    output logic        BUSY,
    output logic [10:0] RAM_ADDR,
    output logic [7:0]  RAM_DI,
    output logic        RAM_DIP,
    output logic        RAM_EN,
    output logic        RAM_WE,
    output logic        RAM_SSR,
    input  logic [7:0]  RAM_DO,
    input  logic        RAM_DOP
);

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [AW-1:0] fill_cnt;
    logic [DW-1:0] fill_byte;
    logic          ready_q;
    logic          busy_q;

    logic          en_nxt;
    logic          we_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] di_nxt;
    logic          dip_nxt;

    logic          rd_q;
    logic          perr_c;

    // FILL_START masks ready in the same cycle so it wins over a pending request
    assign REQ_READY = ready_q & ~FILL_START;
    assign BUSY      = busy_q;

    // Next state and next RAM port drive
    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        we_nxt    = 1'b0;
        addr_nxt  = RAM_ADDR;
        di_nxt    = RAM_DI;
        dip_nxt   = RAM_DIP;
        case (state)
            ST_IDLE: begin
                if (FILL_START) begin
                    state_nxt = ST_FILL;
                end else if (REQ_VALID && REQ_READY) begin
                    en_nxt   = 1'b1;
                    we_nxt   = REQ_WE;
                    addr_nxt = REQ_ADDR;
                    di_nxt   = REQ_DATA;
                    dip_nxt  = (^REQ_DATA) ^ PARITY_ODD;
                end
            end
            ST_FILL: begin
                en_nxt   = 1'b1;
                we_nxt   = 1'b1;
                addr_nxt = fill_cnt;
                di_nxt   = fill_byte;
                dip_nxt  = (^fill_byte) ^ PARITY_ODD;
                if (fill_cnt == {AW{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SSR) begin
            state     <= ST_IDLE;
            fill_cnt  <= '0;
            fill_byte <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt == ST_IDLE);
            busy_q  <= (state_nxt == ST_FILL);
            if (state == ST_IDLE && FILL_START) begin
                fill_cnt  <= '0;
                fill_byte <= FILL_DATA;
            end else if (state == ST_FILL) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
        end
    end

    // Registered RAM port
    always_ff @(posedge CLK) begin
        RAM_SSR <= SSR;
        if (SSR) begin
            RAM_EN   <= 1'b0;
            RAM_WE   <= 1'b0;
            RAM_ADDR <= '0;
            RAM_DI   <= '0;
            RAM_DIP  <= 1'b0;
        end else begin
            RAM_EN   <= en_nxt;
            RAM_WE   <= we_nxt;
            RAM_ADDR <= addr_nxt;
            RAM_DI   <= di_nxt;
            RAM_DIP  <= dip_nxt;
        end
    end

    assign perr_c = (^RAM_DO) ^ RAM_DOP ^ PARITY_ODD;

    // Read-valid shift: port cycle -> RAM output cycle -> response
    always_ff @(posedge CLK) begin
        if (SSR) begin
            rd_q      <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_PERR  <= 1'b0;
            PERR_CNT  <= '0;
        end else begin
            rd_q      <= RAM_EN & ~RAM_WE;
            RSP_VALID <= rd_q;
            if (rd_q) begin
                RSP_DATA <= RAM_DO;
                RSP_PERR <= perr_c;
                if (perr_c && PERR_CNT != {CW{1'b1}}) begin
                    PERR_CNT <= PERR_CNT + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ramb16_s9_ctrl.sv
// Bench for ramb16_s9_ctrl: even and odd parity instances share stimulus, each with
// its own behavioural RAM; read responses are checked against a scoreboard queue.
module tb_ramb16_s9_ctrl;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        perr;
    } exp_t;

    logic        clk;
    logic        ssr;
    logic        req_valid;
    logic        req_we;
    logic [10:0] req_addr;
    logic [7:0]  req_data;
    logic        fill_start;
    logic [7:0]  fill_data;
    logic        flip_en;

    logic [1:0]       req_ready, rsp_valid, rsp_perr, busy, ram_en, ram_we, ram_dip, ram_ssr;
    logic [1:0][7:0]  rsp_data, ram_di;
    logic [1:0][15:0] perr_cnt;
    logic [1:0][10:0] ram_addr;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  model [2048];
    logic [15:0] exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : inst
        logic [7:0] mem [2048];
        logic       memp [2048];
        logic [7:0] dout;
        logic       doutp;

        ramb16_s9_ctrl #(.PARITY_ODD(1'(g))) dut (
            .CLK(clk), .SSR(ssr),
            .REQ_VALID(req_valid), .REQ_READY(req_ready[g]), .REQ_WE(req_we),
            .REQ_ADDR(req_addr), .REQ_DATA(req_data),
            .RSP_VALID(rsp_valid[g]), .RSP_DATA(rsp_data[g]), .RSP_PERR(rsp_perr[g]),
            .PERR_CNT(perr_cnt[g]),
            .FILL_START(fill_start), .FILL_DATA(fill_data), .BUSY(busy[g]),
            .RAM_ADDR(ram_addr[g]), .RAM_DI(ram_di[g]), .RAM_DIP(ram_dip[g]),
            .RAM_EN(ram_en[g]), .RAM_WE(ram_we[g]), .RAM_SSR(ram_ssr[g]),
            .RAM_DO(dout), .RAM_DOP(doutp)
        );

        // Synchronous RAM; flip_en corrupts the parity bit read from 0x010
        always @(posedge clk) begin
            if (ram_en[g]) begin
                if (ram_we[g]) begin
                    mem[ram_addr[g]]  <= ram_di[g];
                    memp[ram_addr[g]] <= ram_dip[g];
                end else begin
                    dout  <= mem[ram_addr[g]];
                    doutp <= memp[ram_addr[g]] ^ (flip_en && ram_addr[g] == 11'h010);
                end
            end
            if (ram_ssr[g]) begin
                dout  <= 8'h00;
                doutp <= 1'b0;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            mon_e = q.pop_front();
            total++; bad++;
            $display("FAIL rsp_missing: no response at cycle %0d (now %0d) want data=%h", mon_e.cyc, cyc, mon_e.data);
        end
        if (rsp_valid != 2'b00) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
                total++; bad++;
                $display("FAIL rsp_unexpected: rsp_valid=%b at cycle %0d, none expected", rsp_valid, cyc);
            end else begin
                mon_e = q.pop_front();
                for (int g = 0; g < 2; g++) begin
                    total++;
                    if ({rsp_valid[g], rsp_data[g], rsp_perr[g]} !== {1'b1, mon_e.data, mon_e.perr}) begin
                        bad++;
                        $display("FAIL rsp[%0d]: got v=%b d=%h p=%b want v=1 d=%h p=%b", g,
                                 rsp_valid[g], rsp_data[g], rsp_perr[g], mon_e.data, mon_e.perr);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic we, input logic [10:0] a, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
        #1;
        total++;
        if (req_ready !== 2'b11) begin
            bad++; $display("FAIL req_ready: got %b want 11", req_ready);
        end
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({ram_en[g], ram_we[g], ram_addr[g]} !== {1'b1, we, a}) begin
                bad++;
                $display("FAIL ram_port[%0d]: got en=%b we=%b a=%h want en=1 we=%b a=%h", g,
                         ram_en[g], ram_we[g], ram_addr[g], we, a);
            end
            if (we) begin
                total++;
                if ({ram_di[g], ram_dip[g]} !== {d, (^d) ^ 1'(g)}) begin
                    bad++;
                    $display("FAIL ram_wdata[%0d]: got di=%h dip=%b want di=%h dip=%b", g,
                             ram_di[g], ram_dip[g], d, (^d) ^ 1'(g));
                end
            end
        end
        if (we) begin
            model[a] = d;
        end else begin
            e.cyc  = cyc + 2;
            e.data = model[a];
            e.perr = flip_en && (a == 11'h010);
            q.push_back(e);
            if (e.perr && exp_cnt != 16'hFFFF) exp_cnt++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0; fill_start = 1'b0;
        end
    endtask

    task automatic check_cnt(input string name);
        for (int g = 0; g < 2; g++) begin
            total++;
            if (perr_cnt[g] !== exp_cnt) begin
                bad++; $display("FAIL %s[%0d]: perr_cnt=%h want %h", name, g, perr_cnt[g], exp_cnt);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({req_ready[g], busy[g], rsp_valid[g], rsp_perr[g], ram_en[g], ram_we[g], ram_dip[g], ram_ssr[g]} !== 8'b0000_0001) begin
                bad++;
                $display("FAIL reset_ctl[%0d]: rdy=%b busy=%b v=%b p=%b en=%b we=%b dip=%b ssr=%b want 00000001", g,
                         req_ready[g], busy[g], rsp_valid[g], rsp_perr[g], ram_en[g], ram_we[g], ram_dip[g], ram_ssr[g]);
            end
            total++;
            if ({rsp_data[g], perr_cnt[g], ram_addr[g], ram_di[g]} !== 43'd0) begin
                bad++;
                $display("FAIL reset_data[%0d]: d=%h cnt=%h a=%h di=%h want all 0", g,
                         rsp_data[g], perr_cnt[g], ram_addr[g], ram_di[g]);
            end
        end
        ssr = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, ram_ssr} !== 4'b1100) begin
            bad++; $display("FAIL reset_release: rdy=%b ram_ssr=%b want 11 00", req_ready, ram_ssr);
        end
    endtask

    task automatic test_write_read;
        do_req(1'b1, 11'h123, 8'h5A);
        do_req(1'b0, 11'h123, 8'h00);
        idle(4);
    endtask

    task automatic test_back_to_back;
        do_req(1'b1, 11'h000, 8'h11);
        do_req(1'b1, 11'h001, 8'h22);
        do_req(1'b1, 11'h7FF, 8'h33);
        do_req(1'b0, 11'h000, 8'h00);
        do_req(1'b0, 11'h001, 8'h00);
        do_req(1'b0, 11'h7FF, 8'h00);
        idle(4);
    endtask

    task automatic test_parity_error;
        do_req(1'b1, 11'h010, 8'h5B);
        idle(2);
        flip_en = 1'b1;
        do_req(1'b0, 11'h010, 8'h00);
        idle(4);
        check_cnt("perr_cnt_one");
        flip_en = 1'b0;
        do_req(1'b0, 11'h010, 8'h00);
        idle(4);
        check_cnt("perr_cnt_hold");
    endtask

    task automatic test_fill;
        int n;
        @(negedge clk);
        fill_start = 1'b1; fill_data = 8'hA5;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h200;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++; $display("FAIL fill_priority: req_ready=%b want 00", req_ready);
        end
        @(posedge clk); #1;
        fill_start = 1'b0; req_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy != 2'b11) break;
            n++;
        end
        total++;
        if (n != 2048) begin
            bad++; $display("FAIL fill_len: busy cycles=%0d want 2048", n);
        end
        total++;
        if ({busy, req_ready} !== 4'b0011) begin
            bad++; $display("FAIL fill_end: busy=%b rdy=%b want 00 11", busy, req_ready);
        end
        for (int i = 0; i < 2048; i++) model[i] = 8'hA5;
        do_req(1'b0, 11'h000, 8'h00);
        do_req(1'b0, 11'h7FF, 8'h00);
        do_req(1'b0, 11'h200, 8'h00);
        idle(4);
    endtask

    task automatic test_reset_mid_fill;
        @(negedge clk);
        fill_start = 1'b1; fill_data = 8'h3C;
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        ssr = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, ram_ssr, req_ready} !== 6'b00_11_00) begin
            bad++; $display("FAIL mid_fill_reset: busy=%b ram_ssr=%b rdy=%b want 00 11 00", busy, ram_ssr, req_ready);
        end
        ssr = 1'b0;
        q.delete();
        exp_cnt = 16'h0000;
        @(negedge clk);
        total++;
        if ({busy, ram_ssr, req_ready} !== 6'b00_00_11) begin
            bad++; $display("FAIL mid_fill_release: busy=%b ram_ssr=%b rdy=%b want 00 00 11", busy, ram_ssr, req_ready);
        end
        for (int i = 0; i < 100; i++) model[i] = 8'h3C;
        do_req(1'b0, 11'd99, 8'h00);
        do_req(1'b0, 11'd100, 8'h00);
        do_req(1'b0, 11'd0, 8'h00);
        idle(4);
    endtask

    task automatic test_perr_saturate;
        flip_en = 1'b1;
        while (exp_cnt != 16'hFFFF) do_req(1'b0, 11'h010, 8'h00);
        idle(4);
        check_cnt("perr_cnt_max");
        do_req(1'b0, 11'h010, 8'h00);
        idle(4);
        check_cnt("perr_cnt_sat");
        flip_en = 1'b0;
    endtask

    initial begin
        ssr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        fill_start = 1'b0; fill_data = '0; flip_en = 1'b0; exp_cnt = 16'h0000;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_parity_error();
        test_fill();
        test_reset_mid_fill();
        test_perr_saturate();
        idle(4);
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL drain: %0d responses outstanding, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
